// File: rtl/pfpu_wb_pkg.sv
// Shared PFPU definitions: latency-slot depth, register-file address width,
// ALU unit indices and the per-unit issue latencies.
package pfpu_wb_pkg;

  localparam int PFPU_MAXLAT = 8;
  localparam int PFPU_ADDRW  = 7;

  typedef enum logic [1:0] {
    UNIT_IF   = 2'd0,
    UNIT_ADD  = 2'd1,
    UNIT_MUL  = 2'd2,
    UNIT_MISC = 2'd3
  } unit_e;

  localparam logic [2:0] PFPU_LAT_IF   = 3'd2;
  localparam logic [2:0] PFPU_LAT_ADD  = 3'd5;
  localparam logic [2:0] PFPU_LAT_MUL  = 3'd4;
  localparam logic [2:0] PFPU_LAT_MISC = 3'd1;

  // When several units report valid at once, the lowest index wins.
  function automatic unit_e lowest_unit(input logic [3:0] v);
    if (v[0])      return UNIT_IF;
    else if (v[1]) return UNIT_ADD;
    else if (v[2]) return UNIT_MUL;
    else           return UNIT_MISC;
  endfunction

endpackage

// File: rtl/pfpu_wb_if.sv
// Bundle of the sequencer issue port, ALU result buses and the register-file
// write-back/status signals seen by pfpu_wb.
interface pfpu_wb_if import pfpu_wb_pkg::*; #(
  parameter int ADDRW = PFPU_ADDRW
);
  logic             issue;
  logic [ADDRW-1:0] issue_dest;
  logic [2:0]       issue_lat;
  logic [31:0]      r0, r1, r2, r3;
  logic [3:0]       v;
  logic             wr_en;
  logic [ADDRW-1:0] wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic [3:0]       pending;
  logic             err_sched, err_coll, err_orphan, err_miss;

  modport master (
    output issue, issue_dest, issue_lat, r0, r1, r2, r3, v,
    input  wr_en, wr_addr, wr_data, busy, pending,
           err_sched, err_coll, err_orphan, err_miss
  );

  modport slave (
    input  issue, issue_dest, issue_lat, r0, r1, r2, r3, v,
    output wr_en, wr_addr, wr_data, busy, pending,
           err_sched, err_coll, err_orphan, err_miss
  );
endinterface

// File: rtl/pfpu_destq.sv
// Destination-address shift register: an entry inserted at slot[lat-1]
// arrives at slot[0] exactly lat cycles later. Callers gate issue_i on a legal latency.
module pfpu_destq import pfpu_wb_pkg::*; #(
  parameter int MAXLAT = PFPU_MAXLAT,
  parameter int ADDRW  = PFPU_ADDRW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  input  logic [ADDRW-1:0] dest_i,
  input  logic [2:0]       lat_i,
  output logic             slot0Valid_o,
  output logic [ADDRW-1:0] slot0Addr_o,
  output logic [3:0]       pending_o,
  output logic             conflict_o
);

  logic [MAXLAT-1:0] valid_q, valid_d;
  logic [ADDRW-1:0]  addr_q [MAXLAT];
  logic [ADDRW-1:0]  addr_d [MAXLAT];
  logic [3:0]        pending_q, pending_d;

  always_comb begin
    valid_d    = valid_q >> 1;
    addr_d     = addr_q;
    conflict_o = 1'b0;
    for (int k = 0; k < MAXLAT - 1; k++) begin
      addr_d[k] = addr_q[k + 1];
    end
    // The new entry wins over whatever shifted into its slot.
    if (issue_i) begin
      conflict_o             = valid_d[lat_i - 3'd1];
      valid_d[lat_i - 3'd1]  = 1'b1;
      addr_d[lat_i - 3'd1]   = dest_i;
    end
    pending_d = '0;
    for (int k = 0; k < MAXLAT; k++) begin
      pending_d = pending_d + {3'b000, valid_d[k]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      pending_q <= '0;
      for (int k = 0; k < MAXLAT; k++) begin
        addr_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
    end
  end

  assign slot0Valid_o = valid_q[0];
  assign slot0Addr_o  = addr_q[0];
  assign pending_o    = pending_q;

endmodule

// File: rtl/pfpu_wb.sv
// PFPU write-back stage: matches ALU valid strobes against the scheduled
// destination queue and drives the registered register-file write port.
module pfpu_wb import pfpu_wb_pkg::*; #(
  parameter int MAXLAT = PFPU_MAXLAT,
  parameter int ADDRW  = PFPU_ADDRW
) (
  input  logic     sys_clk,
  input  logic     alu_rst,
  pfpu_wb_if.slave bus
);

  logic             slot0Valid;
  logic [ADDRW-1:0] slot0Addr;
  logic [3:0]       pending;
  logic             insConflict;
  logic             latOk;
  logic             multiValid;
  logic             doWrite;
  unit_e            selUnit;
  logic [31:0]      selData;

  logic             wrEn_q, wrEn_d;
  logic [ADDRW-1:0] wrAddr_q, wrAddr_d;
  logic [31:0]      wrData_q, wrData_d;
  // err bits: [0] sched, [1] coll, [2] orphan, [3] miss
  logic [3:0]       err_q, err_d;

  assign latOk = (bus.issue_lat != 3'd0) && (32'(bus.issue_lat) < 32'(MAXLAT));

  pfpu_destq #(
    .MAXLAT (MAXLAT),
    .ADDRW  (ADDRW)
  ) u_destq (
    .clk_i        (sys_clk),
    .rst_i        (alu_rst),
    .issue_i      (bus.issue && latOk),
    .dest_i       (bus.issue_dest),
    .lat_i        (bus.issue_lat),
    .slot0Valid_o (slot0Valid),
    .slot0Addr_o  (slot0Addr),
    .pending_o    (pending),
    .conflict_o   (insConflict)
  );

  always_comb begin
    selUnit = lowest_unit(bus.v);
    selData = bus.r0;
    case (selUnit)
      UNIT_IF:   selData = bus.r0;
      UNIT_ADD:  selData = bus.r1;
      UNIT_MUL:  selData = bus.r2;
      UNIT_MISC: selData = bus.r3;
    endcase
    multiValid = (bus.v & (bus.v - 4'd1)) != 4'd0;
    doWrite    = slot0Valid && (bus.v != 4'd0);
    wrEn_d     = doWrite;
    wrAddr_d   = doWrite ? slot0Addr : wrAddr_q;
    wrData_d   = doWrite ? selData : wrData_q;
    err_d      = err_q | {slot0Valid && (bus.v == 4'd0),
                          !slot0Valid && (bus.v != 4'd0),
                          slot0Valid && multiValid,
                          insConflict || (bus.issue && !latOk)};
  end

  // Reset also swallows any issue or valid strobe present in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (alu_rst) begin
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      err_q    <= '0;
    end else begin
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      err_q    <= err_d;
    end
  end

  assign bus.wr_en      = wrEn_q;
  assign bus.wr_addr    = wrAddr_q;
  assign bus.wr_data    = wrData_q;
  assign bus.pending    = pending;
  assign bus.busy       = wrEn_q || (pending != 4'd0);
  assign bus.err_sched  = err_q[0];
  assign bus.err_coll   = err_q[1];
  assign bus.err_orphan = err_q[2];
  assign bus.err_miss   = err_q[3];

endmodule

// File: tb/tb_pfpu_wb.sv
// Self-checking bench for pfpu_wb: directed scenarios plus randomized traffic
// against a model that schedules writes by absolute due cycle.
module tb_pfpu_wb;
  import pfpu_wb_pkg::*;

  localparam int NC = 4096;

  logic sys_clk = 1'b0;
  logic alu_rst;

  pfpu_wb_if #(.ADDRW(PFPU_ADDRW)) bus ();

  pfpu_wb dut (
    .sys_clk (sys_clk),
    .alu_rst (alu_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int compCount = 0;
  int failCount = 0;

  // Model: dueV[c] means a write destination is expected to meet a valid strobe in cycle c.
  bit          dueV [NC];
  logic [6:0]  dueA [NC];
  int          cyc = 0;
  logic        expWrEn;
  logic [6:0]  expWrAddr;
  logic [31:0] expWrData;
  logic [3:0]  expErr;
  int          expPending;
  logic [31:0] rIn [4];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic setResults(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    rIn[0] = a; rIn[1] = b; rIn[2] = c; rIn[3] = d;
  endtask

  // Drive one cycle, advance the model, then compare every output after the edge.
  task automatic applyStimulus(input logic rst, input logic iss, input logic [6:0] dest,
                               input logic [2:0] lat, input logic [3:0] vv);
    bit slot0;
    int first;
    int tgt;
    alu_rst        = rst;
    bus.issue      = iss;
    bus.issue_dest = dest;
    bus.issue_lat  = lat;
    bus.v          = vv;
    bus.r0 = rIn[0]; bus.r1 = rIn[1]; bus.r2 = rIn[2]; bus.r3 = rIn[3];
    if (rst) begin
      for (int i = cyc; i <= cyc + PFPU_MAXLAT; i++) dueV[i] = 1'b0;
      expWrEn = 1'b0; expWrAddr = '0; expWrData = '0; expErr = '0;
    end else begin
      slot0 = dueV[cyc];
      if (slot0 && vv != 4'd0) begin
        first = -1;
        for (int i = 0; i < 4; i++) if (vv[i] && first < 0) first = i;
        expWrEn   = 1'b1;
        expWrAddr = dueA[cyc];
        expWrData = rIn[first];
      end else begin
        expWrEn = 1'b0;
      end
      if (slot0 && $countones(vv) > 1) expErr[1] = 1'b1;
      if (!slot0 && vv != 4'd0)       expErr[2] = 1'b1;
      if (slot0 && vv == 4'd0)        expErr[3] = 1'b1;
      dueV[cyc] = 1'b0;
      if (iss) begin
        if (lat == 3'd0) begin
          expErr[0] = 1'b1;
        end else begin
          tgt = cyc + int'(lat);
          if (dueV[tgt]) expErr[0] = 1'b1;
          dueV[tgt] = 1'b1;
          dueA[tgt] = dest;
        end
      end
    end
    expPending = 0;
    for (int t = cyc + 1; t < cyc + PFPU_MAXLAT; t++) if (dueV[t]) expPending++;
    @(posedge sys_clk);
    #1;
    cyc++;
    checkOutput("wr_en", 32'(bus.wr_en), 32'(expWrEn));
    checkOutput("wr_addr", 32'(bus.wr_addr), 32'(expWrAddr));
    checkOutput("wr_data", bus.wr_data, expWrData);
    checkOutput("pending", 32'(bus.pending), 32'(expPending));
    checkOutput("busy", 32'(bus.busy), 32'((expPending != 0) || expWrEn));
    checkOutput("errs", 32'({bus.err_miss, bus.err_orphan, bus.err_coll, bus.err_sched}),
                32'(expErr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 4'b0000);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 7'h00, 3'd0, 4'b0000);
  endtask

  initial begin
    logic        iss, rst;
    logic [2:0]  lat;
    logic [3:0]  vv;
    logic [2:0]  unitLat [4];
    int          k;
    unitLat[0] = PFPU_LAT_IF;  unitLat[1] = PFPU_LAT_ADD;
    unitLat[2] = PFPU_LAT_MUL; unitLat[3] = PFPU_LAT_MISC;
    expWrEn = 1'b0; expWrAddr = '0; expWrData = '0; expErr = '0; expPending = 0;
    setResults(32'h0, 32'h0, 32'h0, 32'h0);

    doReset();
    doReset();
    checkOutput("reset_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("reset_pending", 32'(bus.pending), 32'd0);

    // Single write with latency 2
    setResults(32'h3F800000, 32'h11111111, 32'h22222222, 32'h33333333);
    applyStimulus(1'b0, 1'b1, 7'h12, 3'd2, 4'b0000);
    idle(1);
    applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 4'b0001);
    checkOutput("basic_wr_en", 32'(bus.wr_en), 32'd1);
    checkOutput("basic_wr_addr", 32'(bus.wr_addr), 32'h12);
    checkOutput("basic_wr_data", bus.wr_data, 32'h3F800000);
    checkOutput("basic_pending", 32'(bus.pending), 32'd0);
    idle(1);
    checkOutput("basic_busy_low", 32'(bus.busy), 32'd0);

    // Out-of-order latencies retire in due order
    doReset();
    applyStimulus(1'b0, 1'b1, 7'h01, 3'd5, 4'b0000);
    applyStimulus(1'b0, 1'b1, 7'h02, 3'd3, 4'b0000);
    applyStimulus(1'b0, 1'b1, 7'h03, 3'd1, 4'b0000);
    applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 4'b0001);
    checkOutput("ooo_addr3", 32'(bus.wr_addr), 32'h03);
    applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 4'b0010);
    checkOutput("ooo_addr2", 32'(bus.wr_addr), 32'h02);
    applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 4'b0100);
    checkOutput("ooo_addr1", 32'(bus.wr_addr), 32'h01);
    checkOutput("ooo_errs", 32'({bus.err_miss, bus.err_orphan, bus.err_coll, bus.err_sched}), 32'd0);

    // Two issues landing on the same cycle
    doReset();
    applyStimulus(1'b0, 1'b1, 7'h20, 3'd3, 4'b0000);
    applyStimulus(1'b0, 1'b1, 7'h21, 3'd2, 4'b0000);
    checkOutput("sched_err", 32'(bus.err_sched), 32'd1);
    idle(1);
    applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 4'b0001);
    checkOutput("sched_addr", 32'(bus.wr_addr), 32'h21);
    idle(2);

    // Collision then orphan
    doReset();
    setResults(32'h0, 32'hA, 32'hB, 32'h0);
    applyStimulus(1'b0, 1'b1, 7'h05, 3'd1, 4'b0000);
    applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 4'b0110);
    checkOutput("coll_data", bus.wr_data, 32'hA);
    checkOutput("coll_err", 32'(bus.err_coll), 32'd1);
    applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 4'b0001);
    checkOutput("orphan_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("orphan_err", 32'(bus.err_orphan), 32'd1);

    // Reset mid-operation with a valid strobe present
    doReset();
    applyStimulus(1'b0, 1'b1, 7'h30, 3'd7, 4'b0000);
    applyStimulus(1'b0, 1'b1, 7'h31, 3'd7, 4'b0000);
    applyStimulus(1'b0, 1'b1, 7'h32, 3'd7, 4'b0000);
    checkOutput("mid_pending3", 32'(bus.pending), 32'd3);
    applyStimulus(1'b1, 1'b0, 7'h00, 3'd0, 4'b0001);
    checkOutput("mid_rst_pending", 32'(bus.pending), 32'd0);
    checkOutput("mid_rst_errs", 32'({bus.err_miss, bus.err_orphan, bus.err_coll, bus.err_sched}), 32'd0);
    idle(10);
    checkOutput("mid_rst_no_write", 32'(bus.wr_en), 32'd0);

    // Zero latency issue, then a missed result
    doReset();
    applyStimulus(1'b0, 1'b1, 7'h08, 3'd0, 4'b0000);
    checkOutput("lat0_err", 32'(bus.err_sched), 32'd1);
    checkOutput("lat0_pending", 32'(bus.pending), 32'd0);
    applyStimulus(1'b0, 1'b1, 7'h09, 3'd2, 4'b0000);
    checkOutput("miss_pending1", 32'(bus.pending), 32'd1);
    idle(1);
    applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 4'b0000);
    checkOutput("miss_err", 32'(bus.err_miss), 32'd1);
    checkOutput("miss_pending0", 32'(bus.pending), 32'd0);

    // Randomized traffic
    doReset();
    for (int n = 0; n < 1500; n++) begin
      setResults($urandom, $urandom, $urandom, $urandom);
      rst = ($urandom_range(0, 59) == 0);
      iss = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) lat = unitLat[$urandom_range(0, 3)];
      else                           lat = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 19) == 0) lat = 3'd0;
      if (lat != 3'd0 && dueV[cyc + int'(lat)] && $urandom_range(0, 7) != 0) iss = 1'b0;
      if (dueV[cyc]) begin
        k = $urandom_range(0, 19);
        if (k == 0)     vv = 4'b0000;
        else if (k < 3) vv = 4'($urandom_range(3, 15));
        else            vv = 4'b0001 << $urandom_range(0, 3);
      end else begin
        vv = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      end
      applyStimulus(rst, iss, 7'($urandom_range(0, 127)), lat, vv);
    end
    idle(PFPU_MAXLAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
